// File: rtl/cal_parser.sv
// Serial ASCII calculator: parses "A op B =" from a byte stream
// and emits a signed 21-bit result or a one-cycle error pulse.
module cal_parser (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [20:0] result,
  output logic        res_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_CALC,
    S_SKIP
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  state_t      state, state_n;
  op_t         op, op_n, op_byte;
  logic [9:0]  a, a_n, b, b_n;
  logic [1:0]  cnt, cnt_n;
  logic [20:0] res_n;
  logic        rv_n, err_n;
  logic        prev;

  logic        take;
  logic        is_dig, is_op, is_term, is_sp;
  logic [3:0]  dig;

  assign take    = rx_valid & ~prev;
  assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_op   = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
                   (rx_data == 8'h2A);
  assign is_term = (rx_data == 8'h3D) || (rx_data == 8'h0D);
  assign is_sp   = (rx_data == 8'h20);
  assign dig     = rx_data[3:0];
  assign op_byte = (rx_data == 8'h2D) ? OP_SUB :
                   (rx_data == 8'h2A) ? OP_MUL : OP_ADD;

  assign busy = (state != S_A) || (cnt != 2'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_A;
      a         <= '0;
      b         <= '0;
      op        <= OP_ADD;
      cnt       <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      prev      <= 1'b0;
    end else begin
      state     <= state_n;
      a         <= a_n;
      b         <= b_n;
      op        <= op_n;
      cnt       <= cnt_n;
      result    <= res_n;
      res_valid <= rv_n;
      err       <= err_n;
      prev      <= rx_valid;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    op_n    = op;
    cnt_n   = cnt;
    res_n   = result;
    rv_n    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_A: begin
        if (take) begin
          unique case (1'b1)
            is_dig && cnt != 2'd3: begin
              a_n   = a * 10'd10 + 10'(dig);
              cnt_n = cnt + 2'd1;
            end
            is_op && cnt != 2'd0: begin
              op_n    = op_byte;
              cnt_n   = 2'd0;
              state_n = S_B;
            end
            is_sp: ;
            // empty lines are not errors
            is_term && cnt == 2'd0: ;
            default: begin
              err_n   = 1'b1;
              a_n     = '0;
              b_n     = '0;
              op_n    = OP_ADD;
              cnt_n   = '0;
              state_n = S_SKIP;
            end
          endcase
        end
      end
      S_B: begin
        if (take) begin
          unique case (1'b1)
            is_dig && cnt != 2'd3: begin
              b_n   = b * 10'd10 + 10'(dig);
              cnt_n = cnt + 2'd1;
            end
            is_term && cnt != 2'd0: state_n = S_CALC;
            is_sp: ;
            default: begin
              err_n   = 1'b1;
              a_n     = '0;
              b_n     = '0;
              op_n    = OP_ADD;
              cnt_n   = '0;
              state_n = S_SKIP;
            end
          endcase
        end
      end
      S_CALC: begin
        unique case (op)
          OP_SUB:  res_n = 21'(a) - 21'(b);
          OP_MUL:  res_n = 21'(a) * 21'(b);
          default: res_n = 21'(a) + 21'(b);
        endcase
        rv_n    = 1'b1;
        a_n     = '0;
        b_n     = '0;
        op_n    = OP_ADD;
        cnt_n   = '0;
        state_n = S_A;
      end
      S_SKIP: begin
        if (take && is_term) state_n = S_A;
      end
      default: state_n = S_A;
    endcase
  end

endmodule

// File: tb/tb_cal_parser.sv
// Randomized self-checking bench for cal_parser against a
// line-level calculator model.
module tb_cal_parser;

  logic        clk;
  logic        n_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [20:0] result;
  logic        res_valid;
  logic        err;
  logic        busy;

  int checks;
  int failures;
  int both;

  logic [21:0] obs[$];
  logic [21:0] exp[$];

  int m_mode;
  int m_a, m_b, m_na, m_nb, m_res;
  byte m_op;

  cal_parser dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .result    (result),
    .res_valid (res_valid),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (n_rst) begin
      if (res_valid) obs.push_back({1'b0, result});
      if (err) obs.push_back({1'b1, 21'd0});
      if (res_valid && err) both++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_mode = 0;
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
    m_op = "+";
    m_res = 0;
  endtask

  task automatic m_clear();
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
    m_op = "+";
  endtask

  // calculator rules applied one received character at a time
  task automatic m_feed(input byte c);
    bit d, o, t, s, bad;
    d = (c >= "0") && (c <= "9");
    o = (c == "+") || (c == "-") || (c == "*");
    t = (c == "=") || (c == 8'h0D);
    s = (c == " ");
    bad = 0;
    if (m_mode == 0) begin
      if (d && m_na < 3) begin
        m_a = m_a * 10 + (c - 48); m_na++;
      end else if (o && m_na > 0) begin
        m_op = c; m_mode = 1;
      end else if (s || (t && m_na == 0)) begin
      end else bad = 1;
    end else if (m_mode == 1) begin
      if (d && m_nb < 3) begin
        m_b = m_b * 10 + (c - 48); m_nb++;
      end else if (t && m_nb > 0) begin
        if (m_op == "+") m_res = m_a + m_b;
        else if (m_op == "-") m_res = m_a - m_b;
        else m_res = m_a * m_b;
        exp.push_back({1'b0, 21'(m_res)});
        m_clear();
        m_mode = 0;
      end else if (s) begin
      end else bad = 1;
    end else begin
      if (t) m_mode = 0;
    end
    if (bad) begin
      exp.push_back({1'b1, 21'd0});
      m_clear();
      m_mode = 2;
    end
  endtask

  task automatic send_byte(input byte c, input int hold, input int gap);
    rx_data = c;
    rx_valid = 1'b1;
    repeat (hold) cyc();
    rx_valid = 1'b0;
    repeat (gap) cyc();
    m_feed(c);
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], hold, $urandom_range(1, 2));
  endtask

  task automatic settle();
    repeat (4) cyc();
  endtask

  task automatic clear_ev();
    obs.delete();
    exp.delete();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #1;
    m_reset();
    repeat (2) cyc();
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    m_reset();
    #2;
    checks += 4;
    if (result !== 21'd0) begin
      failures++; $display("FAIL reset_result got %h exp 0", result);
    end
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL reset_res_valid got %b exp 0", res_valid);
    end
    if (err !== 1'b0) begin
      failures++; $display("FAIL reset_err got %b exp 0", err);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    repeat (2) cyc();
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic test_hold3();
    clear_ev();
    both = 0;
    send_str("1", 3);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL busy_a_digits got %b exp 1", busy);
    end
    send_str("2+34=", 3);
    settle();
    checks += 4;
    if (obs.size() != exp.size()) begin
      failures++;
      $display("FAIL hold3_events got %0d exp %0d", obs.size(), exp.size());
    end
    if (obs.size() != 1 || obs[0] !== {1'b0, 21'd46}) begin
      failures++;
      $display("FAIL hold3_result got %0d events exp one result 46", obs.size());
    end
    if (result !== 21'(m_res)) begin
      failures++; $display("FAIL hold3_model got %0d exp %0d", result, m_res);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL hold3_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_sub_mul();
    clear_ev();
    send_str($sformatf("5-999%c", 8'h0D), 1);
    settle();
    checks += 2;
    if (result !== 21'h1FFC1E) begin
      failures++; $display("FAIL sub_neg got %h exp 1ffc1e", result);
    end
    if (result !== 21'(m_res)) begin
      failures++; $display("FAIL sub_model got %h exp %h", result, 21'(m_res));
    end
    send_str("999*999=", 2);
    settle();
    checks += 2;
    if (result !== 21'd998001) begin
      failures++; $display("FAIL mul_max got %0d exp 998001", result);
    end
    if (obs.size() != 2 || obs[1] !== exp[1]) begin
      failures++; $display("FAIL mul_events got %0d exp 2", obs.size());
    end
  endtask

  task automatic test_digit_overflow();
    clear_ev();
    send_str("1234+1=", 1);
    settle();
    checks += 3;
    if (obs.size() != 1 || obs[0] !== {1'b1, 21'd0}) begin
      failures++; $display("FAIL ovf_err got %0d events exp one err", obs.size());
    end
    if (exp.size() != 1) begin
      failures++; $display("FAIL ovf_model got %0d exp 1", exp.size());
    end
    if (result !== 21'd998001) begin
      failures++; $display("FAIL ovf_hold got %0d exp 998001", result);
    end
    send_str("7+1=", 1);
    settle();
    checks++;
    if (result !== 21'd8) begin
      failures++; $display("FAIL ovf_recover got %0d exp 8", result);
    end
  endtask

  task automatic test_bad_lines();
    clear_ev();
    send_str("+3=", 1);
    send_str("2x5=", 1);
    settle();
    checks += 3;
    if (obs.size() != 2) begin
      failures++; $display("FAIL bad_count got %0d exp 2", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      if (obs[i] !== exp[i] || obs[i][21] !== 1'b1) begin
        failures++; $display("FAIL bad_kind got %h exp %h", obs[i], exp[i]);
      end
    if (result !== 21'd8) begin
      failures++; $display("FAIL bad_hold got %0d exp 8", result);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bad_busy got %b exp 0", busy);
    end
    clear_ev();
    send_str("= =", 1);
    settle();
    checks++;
    if (obs.size() != 0) begin
      failures++; $display("FAIL empty_line got %0d events exp 0", obs.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_ev();
    send_str("12+", 1);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_busy got %b exp 1", busy);
    end
    do_reset();
    checks += 2;
    if (result !== 21'd0) begin
      failures++; $display("FAIL mid_cleared got %0d exp 0", result);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL mid_idle got %b exp 0", busy);
    end
    send_str("3*4", 1);
    checks++;
    if (result !== 21'd0) begin
      failures++; $display("FAIL mid_zero got %0d exp 0", result);
    end
    send_str("=", 1);
    settle();
    checks += 2;
    if (result !== 21'd12) begin
      failures++; $display("FAIL mid_result got %0d exp 12", result);
    end
    if (obs.size() != 1) begin
      failures++; $display("FAIL mid_events got %0d exp 1", obs.size());
    end
  endtask

  task automatic test_valid_at_reset();
    clear_ev();
    n_rst = 1'b0;
    m_reset();
    rx_data = "7";
    rx_valid = 1'b1;
    repeat (2) cyc();
    n_rst = 1'b1;
    cyc();
    m_feed("7");
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rel_accept got %b exp 1", busy);
    end
    rx_valid = 1'b0;
    cyc();
    send_str("+1=", 1);
    settle();
    checks++;
    if (result !== 21'd8) begin
      failures++; $display("FAIL rel_result got %0d exp 8", result);
    end
  endtask

  task automatic test_random();
    string ops;
    string s;
    int a, b, k, h;
    byte o, t;
    ops = "+-*";
    clear_ev();
    both = 0;
    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 999);
      b = $urandom_range(0, 999);
      o = ops[$urandom_range(0, 2)];
      t = ($urandom_range(0, 1) == 1) ? 8'h3D : 8'h0D;
      k = $urandom_range(0, 9);
      case (k)
        6: s = $sformatf("%0d%c%0d%c", 1000 + a, o, b, t);
        7: s = $sformatf("%0dx%0d%c", a, b, t);
        8: s = $sformatf("%c", t);
        9: s = $sformatf("%0d%c%c", a, o, t);
        default:
          s = $sformatf("%s%0d %c%0d%c", (k == 0) ? " " : "", a, o, b, t);
      endcase
      h = $urandom_range(1, 3);
      send_str(s, h);
    end
    settle();
    checks += 3;
    if (obs.size() != exp.size()) begin
      failures++;
      $display("FAIL rand_count got %0d exp %0d", obs.size(), exp.size());
    end
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        failures++; $display("FAIL rand_event%0d got %h exp %h", i, obs[i], exp[i]);
      end
    end
    if (result !== 21'(m_res)) begin
      failures++; $display("FAIL rand_final got %h exp %h", result, 21'(m_res));
    end
    if (both != 0) begin
      failures++; $display("FAIL rv_err_overlap got %0d exp 0", both);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    both = 0;
    test_reset();
    test_hold3();
    test_sub_mul();
    test_digit_overflow();
    test_bad_lines();
    test_reset_mid();
    test_valid_at_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cal_parser.md
CAL_PARSER -- requirements
Module: cal_parser

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The port list SHALL be:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
REQ-003 rx_data  input  8  received ASCII byte from the UART receiver; valid while rx_valid=1.
REQ-004 rx_valid  input  1  receiver byte-ready level; may stay high for several cycles per byte.
REQ-005 result  output  21  signed two's-complement calculation result; held until the next result.
REQ-006 res_valid  output  1  one-cycle pulse marking a new result.
REQ-007 err  output  1  one-cycle pulse marking a malformed expression.
REQ-008 busy  output  1  high whenever the state is not S_A or operand A holds digits.
REQ-009 All flops SHALL be clocked on posedge clk and reset asynchronously when n_rst is low.

Function
REQ-010 A byte SHALL be accepted only on the rising edge of rx_valid (rx_valid=1 and registered previous rx_valid=0), once per byte regardless of how long rx_valid stays high.
REQ-011 Byte classes:
- digit: 0x30-0x39
- operator: '+' 0x2B, '-' 0x2D, '*' 0x2A
- terminator: '=' 0x3D or CR 0x0D
- space: 0x20
- anything else: invalid
REQ-012 The FSM states SHALL be S_A (collect A), S_B (collect B), S_CALC, S_SKIP.
REQ-013 In S_A:
- digit with digit count < 3: A <= A*10 + (byte-0x30), count+1.
- operator with count >= 1: store the operator, clear the count, go to S_B.
- space: ignored.
- any other byte: error.
REQ-014 In S_B:
- digit with count < 3: B <= B*10 + digit, count+1.
- terminator with count >= 1: go to S_CALC.
- space: ignored.
- any other byte: error.
REQ-015 A fourth consecutive digit in either operand SHALL be an error; operands are unsigned 10-bit, range 0-999.
REQ-016 In S_CALC (exactly one cycle), the block SHALL compute the result:
- '+': A+B
- '-': A-B
- '*': A*B
It SHALL register the result, assert res_valid on the following cycle, clear A, B, the operator and the count, and return to S_A.
REQ-017 Latency: a terminator accepted on edge E SHALL produce an updated result and res_valid=1 in the cycle after edge E+1.
REQ-018 An error SHALL:
- assert err for exactly one cycle;
- clear A, B, the operator and the count;
- go to S_SKIP.
The result SHALL be unchanged.
REQ-019 S_SKIP SHALL discard every byte until a terminator is accepted, then go to S_A; no second err SHALL be raised while in S_SKIP.
REQ-020 A terminator received in S_A with count=0 SHALL be ignored, so empty lines cause no error.
REQ-021 A byte edge arriving in the S_CALC cycle SHALL be dropped.
REQ-022 res_valid and err SHALL never be high in the same cycle.

Reset
REQ-023 On n_rst low, the block SHALL immediately set:
- state = S_A
- A, B, the operator and the count = 0
- result = 0
- res_valid = 0, err = 0, busy = 0
- previous-rx_valid register = 0
REQ-024 Reset mid-expression SHALL discard all partial state; the first byte after reset release starts a new expression.
REQ-025 If rx_valid is already high when reset is released, that byte SHALL be accepted on the first clock after release.

Verification
REQ-026 Send "12+34=" with rx_valid held 3 cycles per byte -> one res_valid pulse, result=46; no err.
REQ-027 Send "5-999\r" -> result = -994 (21'h1FFC1E); then "999*999=" -> result=998001.
REQ-028 Send "1234+1=" -> err pulses once on the '4'; no res_valid; then "7+1=" -> result=8.
REQ-029 Send "+3=" then "2x5=" -> err once per line, no res_valid; "= =" alone -> no pulses at all.
REQ-030 Send "12+" then pulse n_rst low, then "3*4=" -> result=12; result reads 0 between reset and that res_valid.
